// File: rtl/hilo_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_if
// Request/response bundle between the EX stage and the HI/LO multiply/divide
// engine.
//
//   start    : single-cycle request, only honoured while the engine is idle
//   op       : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//              100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
//   a, b     : rs / rt operands
//   flush    : squash the in-flight operation
//   hi, lo   : architectural HI/LO registers
//   busy     : operation in flight
//   done     : one-cycle pulse, HI/LO just updated
//   div_zero : sticky divide-by-zero flag
//
// master : EX stage / hazard unit side (drives the request)
// slave  : the engine
// -----------------------------------------------------------------------------
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
// Multi-cycle multiply/divide engine owning the HI/LO register pair.
// Multiplies with an iterative shift-add over a 2*WIDTH product register and
// divides with a restoring algorithm (one quotient bit per cycle). Signed
// operations run on operand magnitudes; the sign is applied in a single FIX
// cycle, which is also where HI/LO are written.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears HI/LO and all flags)
//   bus   : hilo_muldiv_unit_if.slave (start/op/a/b/flush in,
//           hi/lo/busy/done/div_zero out)
//
// Timing: Start edge -> Done-high cycle is WIDTH+2 cycles (WIDTH RUN cycles
// plus one FIX cycle). MTHI/MTLO write on the Start edge and pulse Done in the
// following cycle. Divide-by-zero skips RUN entirely.
// WIDTH must be at least 4.
// -----------------------------------------------------------------------------
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                 state;
  state_e                 state_next;

  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic                   done_q;
  logic                   div_zero_q;

  op_e                    op_q;        // operation in flight
  logic [WIDTH-1:0]       mag_a;       // |A|: multiplicand or dividend
  logic [WIDTH-1:0]       mag_b;       // |B|: multiplier or divisor
  logic                   neg_q;       // product / quotient must be negated
  logic                   a_neg_q;     // dividend was negative (remainder sign)
  logic                   div0_q;      // divide by zero, RUN was skipped
  logic [CNT_W-1:0]       cnt;         // remaining RUN iterations
  // Multiply: running product {upper partial sum, unconsumed multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*WIDTH-1:0]     acc;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  op_e              in_op;
  logic             in_mt;
  logic             in_div;
  logic             in_signed;
  logic             in_b_zero;
  logic             a_sgn;
  logic             b_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // NOTE: every variable driven from always_comb gets a default at the top of
  // the block, so no path through it can leave a value held and infer a latch.
  always_comb begin
    in_op     = op_e'(bus.op);
    in_mt     = (in_op == OP_MTHI) || (in_op == OP_MTLO);
    in_div    = (in_op == OP_DIV) || (in_op == OP_DIVU);
    in_signed = (in_op == OP_MULT) || (in_op == OP_DIV) ||
                (in_op == OP_MADD) || (in_op == OP_MSUB);
    in_b_zero = (bus.b == '0);
    a_sgn     = in_signed & bus.a[WIDTH-1];
    b_sgn     = in_signed & bus.b[WIDTH-1];
    // Negating MIN yields MIN, which read as unsigned is exactly |MIN|.
    a_mag     = a_sgn ? -bus.a : bus.a;
    b_mag     = b_sgn ? -bus.b : bus.b;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        // Flush in the same cycle drops the request; MTHI/MTLO never leave IDLE.
        if (bus.start && !bus.flush && !in_mt) begin
          state_next = (in_div && in_b_zero) ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_next = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath enables
  // ---------------------------------------------------------------------------
  logic busy;
  logic accept;      // load a multi-cycle operation
  logic mt_write;    // MTHI/MTLO write this edge
  logic run_step;    // one shift-add / restoring step this edge
  logic fix_write;   // commit the corrected result to HI/LO this edge

  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    mt_write  = 1'b0;
    run_step  = 1'b0;
    fix_write = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          mt_write = in_mt;
          accept   = !in_mt;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        run_step = !bus.flush;
      end
      S_FIX: begin
        busy      = 1'b1;
        fix_write = !bus.flush;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shift-add multiply or the restoring divide
  // ---------------------------------------------------------------------------
  logic                   op_is_div;
  logic [WIDTH:0]         mul_sum;     // upper half plus optional multiplicand
  logic [WIDTH:0]         div_shift;   // WIDTH+1-bit partial remainder, shifted
  logic                   div_ge;      // divisor fits: quotient bit is 1
  logic [WIDTH-1:0]       div_sub;
  logic [2*WIDTH-1:0]     acc_step;

  always_comb begin
    op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, mag_b});
    // When the divisor fits, the difference is below the divisor and so fits
    // in WIDTH bits; the carry bit of the shifted remainder can be dropped.
    div_sub   = div_shift[WIDTH-1:0] - mag_b;
    if (op_is_div) begin
      acc_step = {(div_ge ? div_sub : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // FIX: sign correction and accumulate against the current HI/LO
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] fix_hilo;

  always_comb begin
    prod_signed = neg_q ? -acc : acc;
    quot_signed = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_signed  = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // Rebuild the original dividend for the divide-by-zero HI value.
    a_orig      = a_neg_q ? -mag_a : mag_a;
    unique case (op_q)
      OP_MULT, OP_MULTU: fix_hilo = prod_signed;
      OP_MADD:           fix_hilo = {hi_q, lo_q} + prod_signed;
      OP_MSUB:           fix_hilo = {hi_q, lo_q} - prod_signed;
      OP_DIV, OP_DIVU:   fix_hilo = div0_q ? {a_orig, {WIDTH{1'b1}}}
                                           : {rem_signed, quot_signed};
      default:           fix_hilo = {hi_q, lo_q};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      op_q       <= OP_MULT;
      mag_a      <= '0;
      mag_b      <= '0;
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      done_q <= 1'b0;

      if (mt_write) begin
        if (in_op == OP_MTLO) begin
          lo_q <= bus.a;
        end else begin
          hi_q <= bus.a;
        end
        done_q     <= 1'b1;
        div_zero_q <= 1'b0;
      end

      if (accept) begin
        op_q       <= in_op;
        mag_a      <= a_mag;
        mag_b      <= b_mag;
        neg_q      <= a_sgn ^ b_sgn;
        a_neg_q    <= a_sgn;
        div0_q     <= in_div && in_b_zero;
        cnt        <= CNT_W'(WIDTH);
        div_zero_q <= 1'b0;
        // Divide shifts the dividend out of the low half; multiply consumes
        // the multiplier from the low half.
        acc        <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
      end

      if (run_step) begin
        acc <= acc_step;
        cnt <= cnt - CNT_W'(1);
      end

      if (fix_write) begin
        {hi_q, lo_q} <= fix_hilo;
        done_q       <= 1'b1;
        if (div0_q) begin
          div_zero_q <= 1'b1;
        end
      end
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Self-checking bench for hilo_muldiv_unit (WIDTH=32): a directed vector table,
// hand-written flush / reset sequences, and randomized operations compared
// against an arithmetic reference model of HI/LO and the divide-by-zero flag.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  logic clk = 1'b0;
  logic reset;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs [15];

  // Issue one request and follow it to its Done pulse. Operands are scrambled
  // right after the Start edge; the engine must not notice.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int busy_cycles, output logic [31:0] hi,
                        output logic [31:0] lo, output logic dz,
                        output logic pulse_low);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = -1; busy_cycles = 0; hi = 'x; lo = 'x; dz = 1'bx; pulse_low = 1'b0;
    for (int c = 1; c <= LAT + 20; c++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat = c; hi = bus.hi; lo = bus.lo; dz = bus.div_zero;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      pulse_low = !bus.done;
    end
  endtask

  task automatic apply_and_check(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo,
                                 input logic exp_dz, input int exp_lat);
    int lat, busy_cycles;
    logic [31:0] hi, lo;
    logic dz, pulse_low;
    run_op(op, a, b, lat, busy_cycles, hi, lo, dz, pulse_low);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
    check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
    check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
    check({tag, "_div_zero"}, {63'b0, dz}, {63'b0, exp_dz});
    check({tag, "_done_pulse"}, {63'b0, pulse_low}, 64'd1);
  endtask

  // MULT that is flushed at cycle fc (cycle 1 = first cycle after Start edge),
  // with a stray Start at cycle 5 that must be ignored.
  task automatic flush_seq(input int fc, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int   done_cnt   = 0;
    int   late_busy  = 0;
    logic busy_at_fc = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'd5;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (c == fc) busy_at_fc = bus.busy;
      if (c > fc && bus.busy) late_busy++;
      bus.start = (c == 5);
      if (c == 5) begin
        bus.op = OP_MTHI; bus.a = 32'hDEADBEEF;
      end
      bus.flush = (c == fc);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    check($sformatf("flush%0d_busy_before", fc), {63'b0, busy_at_fc}, 64'd1);
    check($sformatf("flush%0d_busy_after", fc), 64'(late_busy), 64'd0);
    check($sformatf("flush%0d_no_done", fc), 64'(done_cnt), 64'd0);
    check($sformatf("flush%0d_hi", fc), {32'b0, bus.hi}, {32'b0, exp_hi});
    check($sformatf("flush%0d_lo", fc), {32'b0, bus.lo}, {32'b0, exp_lo});
  endtask

  // Start and Flush together in IDLE: the request is dropped.
  task automatic flush_start_idle(input logic [2:0] op,
                                  input logic [31:0] exp_hi,
                                  input logic [31:0] exp_lo);
    logic [3:0] seen;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = op;
    bus.a = 32'hCAFEF00D; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    seen[3:2] = {bus.done, bus.busy};
    @(negedge clk);
    seen[1:0] = {bus.done, bus.busy};
    check($sformatf("flush_start_op%0d_quiet", op), {60'b0, seen}, 64'd0);
    check($sformatf("flush_start_op%0d_hilo", op), {bus.hi, bus.lo},
          {exp_hi, exp_lo});
  endtask

  // Reference model: HI/LO as one 64-bit value, computed with plain arithmetic.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   inout logic [63:0] hilo, inout logic dz,
                                   output int lat);
    longint sa, sb;
    int     sa32, sb32;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sa32 = $signed(a);
    sb32 = $signed(b);
    lat  = LAT;
    dz   = 1'b0;
    case (op)
      OP_MULT:  hilo = sa * sb;
      OP_MULTU: hilo = {32'b0, a} * {32'b0, b};
      OP_MADD:  hilo = hilo + sa * sb;
      OP_MSUB:  hilo = hilo - sa * sb;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          hilo = {a, 32'hFFFFFFFF}; dz = 1'b1; lat = 2;
        end else if (op == OP_DIVU) begin
          hilo = {a % b, a / b};
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          hilo = {32'h0, 32'h80000000};
        end else begin
          hilo = {32'(sa32 % sb32), 32'(sa32 / sb32)};
        end
      end
      OP_MTHI: begin hilo[63:32] = a; lat = 1; end
      default: begin hilo[31:0]  = a; lat = 1; end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] m_hilo;
    logic        m_dz;
    int          m_lat;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT};
    vecs[2]  = '{OP_MTLO,  32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000005, 1'b0, 1};
    vecs[3]  = '{OP_MTHI,  32'd0,        32'd0,        32'h00000000, 32'h00000005, 1'b0, 1};
    vecs[4]  = '{OP_MADD,  32'd2,        32'd3,        32'h00000000, 32'h0000000B, 1'b0, LAT};
    vecs[5]  = '{OP_MSUB,  32'd4,        32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, LAT};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT};
    vecs[8]  = '{OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
    vecs[9]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, LAT};
    vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT};
    vecs[11] = '{OP_DIV,   32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1, 2};
    vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT};
    vecs[13] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
    vecs[14] = '{OP_MTHI,  32'h00001234, 32'd7,        32'h00001234, 32'hFFFFFFFF, 1'b0, 1};

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000;
    bus.a = '0; bus.b = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {61'b0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      apply_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
    end

    // Flush in RUN and in FIX, and Flush together with Start in IDLE
    flush_seq(10, vecs[14].hi, vecs[14].lo);
    flush_seq(LAT - 1, vecs[14].hi, vecs[14].lo);
    flush_start_idle(OP_MTLO, vecs[14].hi, vecs[14].lo);
    flush_start_idle(OP_MULT, vecs[14].hi, vecs[14].lo);

    // Reset in the middle of a MULT clears everything immediately
    apply_and_check("pre_reset", OP_DIVU, 32'h12345678, 32'd0,
                    32'h12345678, 32'hFFFFFFFF, 1'b1, 2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midop_busy", {63'b0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop_reset_flags", {61'b0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Randomized operations against the reference model
    m_hilo = 64'd0;
    m_dz   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000; b = 32'hFFFFFFFF;
      end
      model_op(op, a, b, m_hilo, m_dz, m_lat);
      apply_and_check($sformatf("rnd%0d_op%0d", i, op), op, a, b,
                      m_hilo[63:32], m_hilo[31:0], m_dz, m_lat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide engine that owns the architectural HI/LO register pair for the datapath.
- Sits beside the single-cycle ALU in the EX stage and takes over mult, multu, madd, msub, div, divu, mthi and mtlo.
- Uses iterative shift-add multiply and restoring divide, with a start/busy/done handshake the hazard unit uses to stall mfhi/mflo.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (minimum 4)
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous active-low reset
Start  input  1  single-cycle request; sampled only in IDLE
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
A  input  WIDTH  rs operand (multiplicand, dividend, or mthi/mtlo source)
B  input  WIDTH  rt operand (multiplier, divisor)
Flush  input  1  abort in-flight operation (branch squash)
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register
Busy  output  1  high while an operation is in flight
Done  output  1  one-cycle pulse when HI/LO have just been updated
DivZero  output  1  sticky flag, set by DIV/DIVU with B==0, cleared by next accepted Start

Behaviour:
- Reset (asynchronous, Reset==0): Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0.
- States: IDLE, RUN, FIX.
- IDLE + Start with Op=MTHI/MTLO: on the same edge, Hi<=A (or Lo<=A); the other half is held. Done=1 for the next cycle; Busy stays 0; no RUN.
- IDLE + Start with any other Op: latch A, B and Op, and latch magnitudes for signed ops (two's-complement negate when MSB=1). Busy<=1, counter<=WIDTH, go to RUN.
- RUN: one iteration per cycle, counter decrements, and RUN lasts WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH product.
  - Divide: restoring algorithm, one quotient bit per cycle, WIDTH+1-bit partial remainder.
  - At counter==1, go to FIX.
- FIX: one cycle. Apply sign correction, then write Hi/Lo. Done<=1 for one cycle, Busy<=0, go to IDLE.
- Total latency: Start edge to Done-high cycle is WIDTH+2 cycles. Hi/Lo hold their new values in the same cycle Done is high.
- Result rules:
  - MULT/MULTU: {Hi,Lo} = signed/unsigned 2*WIDTH product.
  - MADD: {Hi,Lo} += signed product. MSUB: {Hi,Lo} -= signed product. Both wrap modulo 2^(2*WIDTH) and use the Hi/Lo value at the FIX cycle.
  - DIV/DIVU: Lo=quotient, Hi=remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN / -1: Lo=MIN, Hi=0, with no flag.
  - B==0: skip RUN, go straight to FIX. Lo={WIDTH{1}}, Hi=A, DivZero=1.
- Start while Busy: ignored (no queueing). Operands changing during RUN have no effect.
- Flush: synchronous, highest priority after Reset.
  - In RUN/FIX: return to IDLE; Hi/Lo unchanged; no Done; Busy=0 the next cycle.
  - Flush and Start in the same IDLE cycle: Start is dropped.
- Reset mid-operation: immediate return to reset values, and Hi/Lo are cleared.
- Done and Busy are never both high.

Test Plan:
- WIDTH=32, MULT A=FFFFFFFD (-3), B=5 -> Busy for 33 cycles, Done at cycle 34, Hi=FFFFFFFF, Lo=FFFFFFF1.
- MULTU A=FFFFFFFF, B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; then MTLO A=5, MTHI A=0 -> Done the cycle after each Start, Hi=0, Lo=5.
- From Hi:Lo=0:5, MADD 2*3 -> Hi=0, Lo=0000000B; then MSUB 4*3 -> Hi=FFFFFFFF, Lo=FFFFFFFF.
- DIV A=FFFFFFF9 (-7), B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF; DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0.
- DIVU A=12345678, B=0 -> Done after 2 cycles, Lo=FFFFFFFF, Hi=12345678, DivZero=1; next accepted Start clears DivZero.
- Start MULT, reassert Start at cycle 5 (ignored), Flush at cycle 10 -> no Done, Hi/Lo unchanged, Busy low from cycle 11; repeat with Reset low at cycle 10 -> all outputs 0 immediately.
